rename_reg_file: RTL

- Parametrised architectural register file with rename tags for the out-of-order core; each entry holds a committed value plus an "is_ref" flag and ROB id.
- Dispatch renames destinations, ROB commit retires values, and branch logic saves/restores tag-table checkpoints for misprediction recovery.
- Sits between the decode/dispatch stage and the ROB. It generalises the single-write, two-read register file with configurable read ports and tag checkpoints.

---
 rtl/rename_reg_file.sv | 91 +++++++++
 1 files changed

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with rename tags, commit bypass and tag checkpoints
module rename_reg_file #(
  parameter int NUM_READ   = 2,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int REF_W      = 4,
  parameter int NUM_CKPT   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rename_en,
  input  logic [REG_ADDR_W-1:0]          rename_addr,
  input  logic [REF_W-1:0]               rename_id,
  input  logic                           commit_en,
  input  logic [REG_ADDR_W-1:0]          commit_addr,
  input  logic [REF_W-1:0]               commit_id,
  input  logic [DATA_W-1:0]              commit_data,
  input  logic                           flush_en,
  input  logic                           ckpt_save_en,
  input  logic                           ckpt_restore_en,
  input  logic [$clog2(NUM_CKPT)-1:0]    ckpt_idx,
  input  logic [NUM_READ-1:0]            read_en,
  input  logic [NUM_READ*REG_ADDR_W-1:0] read_addr,
  output logic [NUM_READ-1:0]            read_is_ref,
  output logic [NUM_READ*DATA_W-1:0]     read_data,
  output logic [REG_ADDR_W:0]            ref_count
);
  localparam int N = 1 << REG_ADDR_W;
  logic [DATA_W-1:0] reg_val [N];
  logic [N-1:0]      is_ref, is_ref_n, live;
  logic [REF_W-1:0]  ref_id [N];
  logic [REF_W-1:0]  ref_id_n [N];
  logic [N-1:0]      ck_ref [NUM_CKPT];
  logic [N-1:0]      ck_ref_n [NUM_CKPT];
  logic [REF_W-1:0]  ck_id [NUM_CKPT][N];
  logic [REG_ADDR_W:0] cnt_n;
  logic commit_ok, save;
  assign commit_ok = commit_en && commit_addr != '0;
  assign save = ckpt_save_en && !ckpt_restore_en && !flush_en;
  // live is the tag table after the commit clear but before rename/flush/restore
  always_comb begin
    live = is_ref;
    ck_ref_n = ck_ref;
    if (commit_ok && is_ref[commit_addr] && ref_id[commit_addr] == commit_id) live[commit_addr] = 1'b0;
    for (int s = 0; s < NUM_CKPT; s++)
      if (commit_ok && ck_ref[s][commit_addr] && ck_id[s][commit_addr] == commit_id) ck_ref_n[s][commit_addr] = 1'b0;
    is_ref_n = live;
    ref_id_n = ref_id;
    if (flush_en) is_ref_n = '0;
    else if (ckpt_restore_en) begin
      is_ref_n = ck_ref_n[ckpt_idx];
      for (int i = 0; i < N; i++) ref_id_n[i] = ck_id[ckpt_idx][i];
    end else if (rename_en && rename_addr != '0) begin
      is_ref_n[rename_addr] = 1'b1;
      ref_id_n[rename_addr] = rename_id;
    end
    if (save) ck_ref_n[ckpt_idx] = live;
    cnt_n = '0;
    for (int i = 0; i < N; i++) cnt_n = cnt_n + (REG_ADDR_W+1)'(is_ref_n[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      is_ref <= '0;
      ref_count <= '0;
      for (int i = 0; i < N; i++) begin
        reg_val[i] <= '0;
        ref_id[i] <= '0;
      end
      for (int s = 0; s < NUM_CKPT; s++) begin
        ck_ref[s] <= '0;
        for (int i = 0; i < N; i++) ck_id[s][i] <= '0;
      end
    end else begin
      if (commit_ok) reg_val[commit_addr] <= commit_data;
      is_ref <= is_ref_n;
      ref_id <= ref_id_n;
      ck_ref <= ck_ref_n;
      ref_count <= cnt_n;
      if (save) for (int i = 0; i < N; i++) ck_id[ckpt_idx][i] <= ref_id[i];
    end
  end
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [REG_ADDR_W-1:0] a;
    logic hit, byp;
    assign a = read_addr[p*REG_ADDR_W +: REG_ADDR_W];
    assign hit = !rst && read_en[p] && a != '0;
    assign byp = commit_en && commit_addr == a && is_ref[a] && ref_id[a] == commit_id;
    assign read_is_ref[p] = hit && !byp && is_ref[a];
    assign read_data[p*DATA_W +: DATA_W] = !hit ? '0 : byp ? commit_data : is_ref[a] ? DATA_W'(ref_id[a]) : reg_val[a];
  end
endmodule
